load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- MEM-stage load/store controller for the MIPS core; sits directly upstream of mem_data.
- Accepts one byte-addressed memory request at a time from the EX/MEM pipeline register and drives the word-wide mem_data port (addr/rd/wr/wdata/rdata).
- Handles sub-word loads with sign/zero extension, and sub-word stores via read-modify-write.
- Returns aligned load data to writeback; stalls the pipeline through req_ready.

Parameters:
- ADDR_W, 7, word-address width of mem_data; byte address bits [ADDR_W+1:2] select the word, higher bits ignored (wrap).

Ports:
- clk  in  1  core clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present from EX/MEM
- req_ready  out  1  high only in IDLE; request accepted when req_valid&&req_ready
- req_op  in  3  operation code (package enum)
- req_addr  in  32  byte address
- req_wdata  in  32  store data; sub-word stores use the low bits
- resp_valid  out  1  one-cycle pulse: request complete
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  qualified by resp_valid: misaligned request, no memory access made
- busy  out  1  high in every state except IDLE
- mem_addr  out  ADDR_W  word address to mem_data
- mem_rd  out  1  read strobe
- mem_wr  out  1  write strobe
- mem_wdata  out  32  write data
- mem_rdata  in  32  read data; valid the cycle after mem_rd is sampled high

Behaviour:
- Reset values: req_ready=1; busy, resp_valid, resp_err, mem_rd, mem_wr = 0; resp_rdata, mem_addr, mem_wdata = 0; state=IDLE. Reset is asynchronous, so strobes drop immediately, even mid-operation. No partial write may complete after reset asserts.
- All outputs are registered. Op, address and wdata are latched on accept.
- Byte order is little-endian: byte k = bits [8k+7:8k]; halfword at addr[1]=1 is bits [31:16].
- IDLE: on accept, the next state is:
  - ERR if misaligned (LW/SW with addr[1:0]!=0; LH/LHU/SH with addr[0]!=0).
  - LD_RD for loads.
  - ST_WR for SW.
  - RMW_RD for SH/SB.
- LD_RD: mem_rd=1 for 1 cycle, then LD_DATA.
- LD_DATA: mem_rdata sampled and lane-selected. LB/LH sign-extend; LBU/LHU zero-extend; LW passes through. resp_valid=1 with the data; return to IDLE.
- Load latency: accept at cycle N gives resp_valid at N+2.
- ST_WR: mem_wr=1, mem_wdata=latched wdata, resp_valid=1 in the same cycle; return to IDLE. Latency N+1.
- RMW_RD: mem_rd=1 for 1 cycle, then RMW_WR.
- RMW_WR: merge the addressed lane(s) of wdata into mem_rdata, leaving other bytes unchanged. mem_wr=1, resp_valid=1; return to IDLE. Latency N+2.
- ERR: resp_valid=1, resp_err=1, resp_rdata=0, no strobes; return to IDLE. Latency N+1.
- mem_rd and mem_wr are never high together. mem_addr is held stable across RMW_RD/RMW_WR.
- req_valid while busy is ignored. The request must be held by upstream until accepted.
- Next request is accepted no earlier than the cycle after resp_valid. Throughput is ≤1 request per 2 cycles.
- Invalid op values cannot occur: all 8 encodings are defined.

Optional Feature:
- LSU_ALIGN_CHECK_EN
  - Defined: misalignment detection and the ERR path as above.
  - Undefined: ERR state removed and resp_err tied 0. Misaligned addresses are force-aligned (addr[1:0] cleared for word ops, addr[0] cleared for halfword ops) and executed normally.

Decomposition:
- Package lsu_pkg: op enum (LW=0, LH=1, LHU=2, LB=3, LBU=4, SW=5, SH=6, SB=7), state enum (IDLE, LD_RD, LD_DATA, ST_WR, RMW_RD, RMW_WR, ERR), and helper constants is_load/is_store/op size.
- One sub-module, lsu_lane_align: combinational extract/extend for loads and merge for stores. Inputs are op, addr[1:0], word and wdata.

Test Plan:
- SW addr 0x08 data 0x11223344 → mem_wr pulse with mem_addr=2, mem_wdata=0x11223344; resp_valid at N+1, resp_err=0.
- After the above, LB 0x09 → 0x00000033; LBU 0x0B → 0x00000011; LH 0x0A → 0x00001122; each resp_valid at N+2.
- SB 0x0A data 0xFFFFFF80 → RMW read then write of 0x11803344; following LB 0x0A → 0xFFFFFF80, LW 0x08 → 0x11803344.
- LH 0x09 and SW 0x0A with the macro defined → resp_err=1, resp_rdata=0, no mem_rd/mem_wr. With the macro undefined, SW 0x0A writes word 2.
- Drop rst_n during RMW_RD of SB 0x08 → mem_rd falls immediately, mem_wr never asserts, word 2 unchanged, req_ready=1 after release.
- Back-to-back req_valid held high with LW,LW → second accepted the cycle after the first resp_valid; req_ready low throughout busy.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the MEM-stage load/store unit.
// Op/state enums, latched-request bundle, size and alignment helpers.
package lsu_pkg;

   typedef enum logic [2:0] {
      LW  = 3'd0,
      LH  = 3'd1,
      LHU = 3'd2,
      LB  = 3'd3,
      LBU = 3'd4,
      SW  = 3'd5,
      SH  = 3'd6,
      SB  = 3'd7
   } lsu_op_e;

   typedef enum logic [2:0] {
      IDLE,
      LD_RD,
      LD_DATA,
      ST_WR,
      RMW_RD,
      RMW_WR,
      ERR
   } lsu_state_e;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;

   typedef struct packed {
      lsu_op_e     op;
      logic [1:0]  off;
      logic [31:0] wdata;
   } lsu_req_t;

   function automatic logic is_load(input lsu_op_e op);
      return op inside {LW, LH, LHU, LB, LBU};
   endfunction

   function automatic logic is_store(input lsu_op_e op);
      return !is_load(op);
   endfunction

   function automatic logic [1:0] op_size(input lsu_op_e op);
      logic [1:0] sz;
      sz = SZ_B;
      if (op inside {LW, SW})
         sz = SZ_W;
      else if (op inside {LH, LHU, SH})
         sz = SZ_H;
      return sz;
   endfunction

   function automatic logic misaligned(input lsu_op_e op,
                                       input logic [1:0] off);
      logic m;
      m = 1'b0;
      if (op_size(op) == SZ_W)
         m = (off != 2'b00);
      else if (op_size(op) == SZ_H)
         m = off[0];
      return m;
   endfunction

   // Drop the low offset bits a word/halfword op cannot use.
   function automatic logic [1:0] align_off(input lsu_op_e op,
                                            input logic [1:0] off);
      logic [1:0] o;
      o = off;
      if (op_size(op) == SZ_W)
         o = 2'b00;
      else if (op_size(op) == SZ_H)
         o = {off[1], 1'b0};
      return o;
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane logic: load extract/extend, sub-word store merge.
// In: op, addr (byte offset), word (mem_rdata), wdata. Out: ldata, mdata.
module lsu_lane_align
   import lsu_pkg::*;
(
   input  lsu_op_e     op,
   input  logic [1:0]  addr,
   input  logic [31:0] word,
   input  logic [31:0] wdata,
   output logic [31:0] ldata,
   output logic [31:0] mdata
);

   logic [7:0]  b;
   logic [15:0] h;

   always_comb begin
      b     = word[{addr, 3'b000} +: 8];
      h     = word[{addr[1], 4'b0000} +: 16];
      ldata = word;
      mdata = wdata;
      unique case (op)
         LB:  ldata = {{24{b[7]}}, b};
         LBU: ldata = {24'd0, b};
         LH:  ldata = {{16{h[15]}}, h};
         LHU: ldata = {16'd0, h};
         SH: begin
            mdata = word;
            mdata[{addr[1], 4'b0000} +: 16] = wdata[15:0];
         end
         SB: begin
            mdata = word;
            mdata[{addr, 3'b000} +: 8] = wdata[7:0];
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store controller driving the word-wide mem_data port.
// Ports: req_* from EX/MEM, resp_* to writeback, mem_* to mem_data, busy.
// LSU_ALIGN_CHECK_EN: misaligned -> ERR; else force-align and execute.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int ADDR_W = 7
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [2:0]        req_op,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic              busy,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   output logic              mem_wr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   lsu_state_e  state, state_n;
   lsu_req_t    req_q;
   lsu_op_e     op_in;
   logic        accept;
   logic [31:0] ldata, mdata;

   logic              ready_d, busy_d, rd_d, wr_d;
   logic              rv_d, err_d;
   logic [31:0]       rdata_d, wdata_d;
   logic [ADDR_W-1:0] addr_d;

   // Byte address bits above the word index wrap.
   logic unused_addr;
   assign unused_addr = ^req_addr[31:ADDR_W+2];

   assign op_in  = lsu_op_e'(req_op);
   assign accept = req_valid && req_ready;

   lsu_lane_align u_align (
      .op    (req_q.op),
      .addr  (req_q.off),
      .word  (mem_rdata),
      .wdata (req_q.wdata),
      .ldata (ldata),
      .mdata (mdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_n;
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE: begin
            if (accept) begin
`ifdef LSU_ALIGN_CHECK_EN
               if (misaligned(op_in, req_addr[1:0]))
                  state_n = ERR;
               else
`endif
               if (is_load(op_in))
                  state_n = LD_RD;
               else if (op_in == SW)
                  state_n = ST_WR;
               else
                  state_n = RMW_RD;
            end
         end
         LD_RD:   state_n = LD_DATA;
         LD_DATA: state_n = IDLE;
         ST_WR:   state_n = IDLE;
         RMW_RD:  state_n = RMW_WR;
         RMW_WR:  state_n = IDLE;
`ifdef LSU_ALIGN_CHECK_EN
         ERR:     state_n = IDLE;
`endif
         default: state_n = IDLE;
      endcase
   end

   // Read strobes follow the state being entered so the sync RAM
   // returns data during LD_DATA/RMW_WR; writes and responses are
   // issued as the terminal state retires.
   always_comb begin
      ready_d = (state_n == IDLE);
      busy_d  = (state_n != IDLE);
      rd_d    = (state_n == LD_RD) || (state_n == RMW_RD);
      wr_d    = 1'b0;
      rv_d    = 1'b0;
      err_d   = 1'b0;
      rdata_d = '0;
      wdata_d = mem_wdata;
      addr_d  = mem_addr;
      if (accept)
         addr_d = req_addr[ADDR_W+1:2];
      unique case (state)
         LD_DATA: begin
            rv_d    = 1'b1;
            rdata_d = ldata;
         end
         ST_WR: begin
            rv_d    = 1'b1;
            wr_d    = 1'b1;
            wdata_d = req_q.wdata;
         end
         RMW_WR: begin
            rv_d    = 1'b1;
            wr_d    = 1'b1;
            wdata_d = mdata;
         end
`ifdef LSU_ALIGN_CHECK_EN
         ERR: begin
            rv_d  = 1'b1;
            err_d = 1'b1;
         end
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_q      <= '0;
         req_ready  <= 1'b1;
         busy       <= 1'b0;
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         resp_rdata <= '0;
         mem_rd     <= 1'b0;
         mem_wr     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
      end else begin
         if (accept) begin
            req_q.op    <= op_in;
            req_q.wdata <= req_wdata;
`ifdef LSU_ALIGN_CHECK_EN
            req_q.off   <= req_addr[1:0];
`else
            req_q.off   <= align_off(op_in, req_addr[1:0]);
`endif
         end
         req_ready  <= ready_d;
         busy       <= busy_d;
         resp_valid <= rv_d;
         resp_err   <= err_d;
         resp_rdata <= rdata_d;
         mem_rd     <= rd_d;
         mem_wr     <= wr_d;
         mem_addr   <= addr_d;
         mem_wdata  <= wdata_d;
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: sync RAM model, reference model, random ops.
// Covers directed cases, async reset mid-RMW and back-to-back accept.
module tb_load_store_unit;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_op;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        busy;
   logic [6:0]  mem_addr;
   logic        mem_rd;
   logic        mem_wr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   load_store_unit #(.ADDR_W(7)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .busy       (busy),
      .mem_addr   (mem_addr),
      .mem_rd     (mem_rd),
      .mem_wr     (mem_wr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
   );

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int rd_cnt = 0;
   int wr_cnt = 0;
   bit overlap = 0;
   bit rdy_bad = 0;

   logic [31:0] ram     [128];
   logic [31:0] ref_mem [128];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) begin
      cyc++;
      if (mem_rd) begin
         mem_rdata <= ram[mem_addr];
         rd_cnt++;
      end
      if (mem_wr) begin
         ram[mem_addr] = mem_wdata;
         wr_cnt++;
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if (mem_rd && mem_wr)
            overlap = 1;
         if (busy == req_ready)
            rdy_bad = 1;
      end
   end

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h, want %h", tag, got, exp);
      end
   endtask

   // Reference: size from op, little-endian lanes by arithmetic.
   task automatic ref_exec(input int op,
                           input logic [31:0] addr,
                           input logic [31:0] wd,
                           output logic [31:0] rdat,
                           output bit err,
                           output int lat,
                           output int nrd,
                           output int nwr);
      int unsigned idx, off, size;
      longint unsigned mask, lane, w;
      size = (op == 0 || op == 5) ? 4 :
             (op == 1 || op == 2 || op == 6) ? 2 : 1;
      idx  = (addr / 4) % 128;
      off  = addr % 4;
      rdat = 0;
      err  = 0;
      if (off % size != 0) begin
`ifdef LSU_ALIGN_CHECK_EN
         err = 1;
         lat = 1;
         nrd = 0;
         nwr = 0;
         return;
`else
         off = off - off % size;
`endif
      end
      mask = (64'd1 << (8 * size)) - 1;
      w    = ref_mem[idx];
      if (op < 5) begin
         lane = (w >> (8 * off)) & mask;
         if ((op == 1 || op == 3) && lane > mask / 2)
            lane = lane - (mask + 1);
         rdat = lane[31:0];
         lat  = 2;
         nrd  = 1;
         nwr  = 0;
      end else begin
         w = (w & ~(mask << (8 * off))) |
             ((longint'(wd) & mask) << (8 * off));
         ref_mem[idx] = w[31:0];
         lat = (size == 4) ? 1 : 2;
         nrd = (size == 4) ? 0 : 1;
         nwr = 1;
      end
   endtask

   // Called at a negedge; returns at a negedge.
   task automatic do_req(input int op,
                         input logic [31:0] addr,
                         input logic [31:0] wd,
                         output logic [31:0] got);
      logic [31:0] er;
      bit ee;
      int el, erd, ewr, n;
      int unsigned idx;
      idx = (addr / 4) % 128;
      ref_exec(op, addr, wd, er, ee, el, erd, ewr);
      rd_cnt    = 0;
      wr_cnt    = 0;
      req_valid = 1'b1;
      req_op    = op[2:0];
      req_addr  = addr;
      req_wdata = wd;
      n = 0;
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      req_valid = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!resp_valid && n < 8);
      got = resp_rdata;
      chk("latency", n, el);
      chk("rdata", resp_rdata, er);
      chk("err", {31'd0, resp_err}, {31'd0, ee});
      @(negedge clk);
      chk("pulse", {31'd0, resp_valid}, 0);
      chk("rd_cnt", rd_cnt, erd);
      chk("wr_cnt", wr_cnt, ewr);
      chk("word", ram[idx], ref_mem[idx]);
   endtask

   initial begin
      logic [31:0] r;
      int n, acc2, r1;
      for (int i = 0; i < 128; i++) begin
         ram[i]     = $urandom;
         ref_mem[i] = ram[i];
      end
      req_valid = 0;
      req_op    = 0;
      req_addr  = 0;
      req_wdata = 0;
      rst_n     = 1;
      #3 rst_n  = 0;
      repeat (2) @(negedge clk);
      chk("rst_ready", {31'd0, req_ready}, 1);
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_rv", {31'd0, resp_valid}, 0);
      chk("rst_err", {31'd0, resp_err}, 0);
      chk("rst_rd", {31'd0, mem_rd}, 0);
      chk("rst_wr", {31'd0, mem_wr}, 0);
      chk("rst_rdata", resp_rdata, 0);
      chk("rst_addr", {25'd0, mem_addr}, 0);
      chk("rst_wdata", mem_wdata, 0);
      rst_n = 1;
      @(negedge clk);

      do_req(5, 32'h08, 32'h11223344, r);
      chk("sw_word2", ram[2], 32'h11223344);
      do_req(3, 32'h09, 0, r);
      chk("lb_09", r, 32'h00000033);
      do_req(4, 32'h0B, 0, r);
      chk("lbu_0b", r, 32'h00000011);
      do_req(1, 32'h0A, 0, r);
      chk("lh_0a", r, 32'h00001122);
      do_req(7, 32'h0A, 32'hFFFFFF80, r);
      chk("sb_word2", ram[2], 32'h11803344);
      do_req(3, 32'h0A, 0, r);
      chk("lb_0a", r, 32'hFFFFFF80);
      do_req(0, 32'h08, 0, r);
      chk("lw_08", r, 32'h11803344);
      do_req(1, 32'h09, 0, r);
`ifdef LSU_ALIGN_CHECK_EN
      chk("lh_09", r, 32'h0);
`else
      chk("lh_09", r, 32'h00003344);
`endif
      do_req(5, 32'h0A, 32'hCAFEF00D, r);

      // Async reset while SB 0x08 is in its read phase.
      rd_cnt    = 0;
      wr_cnt    = 0;
      req_valid = 1'b1;
      req_op    = 3'd7;
      req_addr  = 32'h08;
      req_wdata = 32'h000000AB;
      @(negedge clk);
      req_valid = 1'b0;
      chk("rmw_rd_on", {31'd0, mem_rd}, 1);
      rst_n = 0;
      #1;
      chk("rst_rd_drop", {31'd0, mem_rd}, 0);
      chk("rst_busy_drop", {31'd0, busy}, 0);
      repeat (2) @(negedge clk);
      rst_n = 1;
      repeat (3) @(negedge clk);
      chk("rst_no_wr", wr_cnt, 0);
      chk("rst_word2", ram[2], ref_mem[2]);
      chk("rst_ready_after", {31'd0, req_ready}, 1);

      // Back-to-back LW with req_valid held.
      req_valid = 1'b1;
      req_op    = 3'd0;
      req_addr  = 32'h08;
      @(negedge clk);
      req_addr = 32'h0C;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!resp_valid && n < 8);
      r1 = cyc;
      chk("b2b_lat1", n, 2);
      chk("b2b_data1", resp_rdata, ref_mem[2]);
      n = 0;
      while (!req_ready && n < 10) begin
         @(negedge clk);
         n++;
      end
      acc2 = cyc + 1;
      chk("b2b_gap", acc2 - r1, 1);
      @(negedge clk);
      req_valid = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!resp_valid && n < 8);
      chk("b2b_lat2", n, 2);
      chk("b2b_data2", resp_rdata, ref_mem[3]);
      @(negedge clk);

      for (int i = 0; i < 250; i++) begin
         int op;
         logic [31:0] a;
         op = $urandom_range(0, 7);
         a  = $urandom;
         if (i % 2 == 0)
            a = a & 32'h1F;
         do_req(op, a, $urandom, r);
      end

      chk("rd_wr_excl", {31'd0, overlap}, 0);
      chk("ready_busy", {31'd0, rdy_bad}, 0);
      for (int i = 0; i < 128; i++)
         chk("final_mem", ram[i], ref_mem[i]);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
